// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer feeding one 1-bit ALU slice, LSB first, carry rippled through a register.
// Latency: accept at cycle 0, Done pulse at cycle WIDTH+1; one operation per WIDTH+2 cycles.
// Backpressure: Ready=0 from accept until Done; Start is ignored (not queued) while busy.
module alu_bit_serial_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    output logic             Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Operation,
    input  logic             Bnegate,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             SliceA,
    output logic             SliceB,
    output logic             SliceCIN,
    output logic             SliceBnegate,
    output logic             SliceLess,
    output logic [2:0]       SliceOp,
    input  logic             SliceResult,
    input  logic             SliceCOUT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [2:0]       op_q,     op_d;
    logic             bneg_q,   bneg_d;
    logic             slt_q,    slt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             run;
    logic             last_bit;

    assign run      = (state_q == ST_RUN);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        bneg_d   = bneg_q;
        slt_d    = slt_q;
        carry_d  = carry_q;
        shreg_d  = shreg_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    // SLT runs as a subtract; the sign fix-up happens when the word is finalised
                    slt_d   = (Operation == OP_SLT);
                    op_d    = (Operation == OP_SLT) ? OP_ADD : Operation;
                    bneg_d  = Bnegate | (Operation == OP_SLT);
                    carry_d = Bnegate | (Operation == OP_SLT);
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                shreg_d[cnt_q] = SliceResult;
                carry_d        = SliceCOUT;
                cnt_d          = cnt_q + 1'b1;
                if (last_bit) begin
                    cout_d   = SliceCOUT;
                    ovf_d    = carry_q ^ SliceCOUT;
                    result_d = slt_q ? {{(WIDTH-1){1'b0}}, SliceResult ^ carry_q ^ SliceCOUT}
                                     : shreg_d;
                    zero_d   = (result_d == '0);
                    state_d  = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            bneg_q   <= 1'b0;
            slt_q    <= 1'b0;
            carry_q  <= 1'b0;
            shreg_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            bneg_q   <= bneg_d;
            slt_q    <= slt_d;
            carry_q  <= carry_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Ready        = (state_q == ST_IDLE);
    assign Done         = (state_q == ST_FIN);
    assign Result       = result_q;
    assign Zero         = zero_q;
    assign CarryOut     = cout_q;
    assign Overflow     = ovf_q;
    assign SliceA       = run & a_q[cnt_q];
    assign SliceB       = run & b_q[cnt_q];
    assign SliceCIN     = run & carry_q;
    assign SliceBnegate = run & bneg_q;
    assign SliceLess    = 1'b0;
    assign SliceOp      = run ? op_q : 3'b000;

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Directed bench for alu_bit_serial_seq with a behavioural 1-bit ALU slice attached.
module tb_alu_bit_serial_seq;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic [15:0] a_in, b_in;
    logic [2:0]  op_in;
    logic        bneg_in;
    logic        done;
    logic [15:0] result;
    logic        zero, carry_out, overflow;
    logic        s_a, s_b, s_cin, s_bneg, s_less;
    logic [2:0]  s_op;
    logic        s_res, s_cout;
    logic        s_beff;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    alu_bit_serial_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .Clock(clock), .Reset(rst_n), .Start(start), .Ready(ready),
        .A(a_in), .B(b_in), .Operation(op_in), .Bnegate(bneg_in),
        .Done(done), .Result(result), .Zero(zero), .CarryOut(carry_out), .Overflow(overflow),
        .SliceA(s_a), .SliceB(s_b), .SliceCIN(s_cin), .SliceBnegate(s_bneg),
        .SliceLess(s_less), .SliceOp(s_op), .SliceResult(s_res), .SliceCOUT(s_cout)
    );

    // 1-bit slice: 000 AND, 001 OR, 011 XOR, 100 SUM, 110 NOR
    assign s_beff = s_b ^ s_bneg;
    assign s_cout = (s_a & s_beff) | (s_a & s_cin) | (s_beff & s_cin);
    always_comb begin
        s_res = 1'b0;
        case (s_op)
            3'b000:  s_res = s_a & s_beff;
            3'b001:  s_res = s_a | s_beff;
            3'b011:  s_res = s_a ^ s_beff;
            3'b100:  s_res = s_a ^ s_beff ^ s_cin;
            3'b110:  s_res = ~(s_a | s_beff);
            default: s_res = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic bneg, input logic [15:0] exp_res,
                          input logic exp_z, input logic check_cv, input logic exp_c,
                          input logic exp_v);
        int lat;
        @(negedge clock);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        a_in = a; b_in = b; op_in = op; bneg_in = bneg; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a_in = ~a; b_in = ~b; op_in = 3'b001; bneg_in = ~bneg;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clock);
        end
        check({tag, "_latency"}, 32'(lat), 32'd17);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_zero"}, 32'(zero), 32'(exp_z));
        if (check_cv) begin
            check({tag, "_cout"}, 32'(carry_out), 32'(exp_c));
            check({tag, "_ovf"}, 32'(overflow), 32'(exp_v));
        end
        @(negedge clock);
        check({tag, "_after"}, {14'd0, done, ready, result}, {14'd0, 1'b0, 1'b1, exp_res});
    endtask

    initial begin
        int ready_bad, ndone, done_cyc, extra;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; op_in = '0; bneg_in = 1'b0;
        #12;
        check("rst_flags", {27'd0, ready, done, zero, carry_out, overflow}, 32'b10100);
        check("rst_result", 32'(result), 32'd0);
        check("rst_slice", {24'd0, s_a, s_b, s_cin, s_bneg, s_less, s_op}, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        run_op("add_ovf", 16'h7FFF, 16'h0001, 3'b100, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub_neg", 16'h0005, 16'h0007, 3'b100, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sub_eq",  16'h1234, 16'h1234, 3'b100, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("slt_neg", 16'hFFFD, 16'h0005, 3'b111, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_ovf", 16'h8000, 16'h7FFF, 3'b111, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("slt_no",  16'h0005, 16'hFFFD, 3'b111, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("and",     16'hF0F0, 16'hFF00, 3'b000, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("xor",     16'hF0F0, 16'hFF00, 3'b011, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start held high through the run while operands keep changing
        @(negedge clock);
        a_in = 16'h0003; b_in = 16'h0004; op_in = 3'b100; bneg_in = 1'b0; start = 1'b1;
        ready_bad = 0; ndone = 0; done_cyc = 0; extra = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clock);
            a_in = 16'($urandom); b_in = 16'($urandom);
            if (ready) ready_bad++;
            if (done) begin
                ndone++;
                done_cyc = c;
            end
        end
        start = 1'b0;
        check("hs_result", 32'(result), 32'h0007);
        for (int c = 18; c <= 22; c++) begin
            @(negedge clock);
            if (c == 18) check("hs_ready18", 32'(ready), 32'd1);
            if (done) extra++;
        end
        check("hs_ready_low", 32'(ready_bad), 32'd0);
        check("hs_one_done", 32'(ndone), 32'd1);
        check("hs_done_cyc", 32'(done_cyc), 32'd17);
        check("hs_no_extra", 32'(extra), 32'd0);

        // Reset asserted in the middle of a run
        a_in = 16'h00FF; b_in = 16'hFF01; op_in = 3'b100; bneg_in = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 2; c <= 8; c++) @(negedge clock);
        rst_n = 1'b0;
        #1;
        check("mrst_flags", {27'd0, ready, done, zero, carry_out, overflow}, 32'b10100);
        check("mrst_result", 32'(result), 32'd0);
        check("mrst_slice", {24'd0, s_a, s_b, s_cin, s_bneg, s_less, s_op}, 32'd0);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done) extra++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done) extra++;
        end
        check("mrst_no_done", 32'(extra), 32'd0);
        run_op("post_rst", 16'h1111, 16'h2222, 3'b100, 1'b0, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_checks);
        $fatal(1);
    end

endmodule
